// File: rtl/byte_word_packer_if.sv
// Byte-in / word-out handshake bundle for byte_word_packer.
//   in_valid/in_ready/in_byte/in_last : byte stream into the packer
//   out_valid/out_ready/out_word/out_bytes : packed word stream out
//   word_count : running count of words handed off (mod 2^16)
// slave  : the packer side.
// master : the producer/consumer side (testbench or surrounding logic).
interface byte_word_packer_if;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_byte;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [2:0]  out_bytes;
  logic [15:0] word_count;

  modport slave (
    input  in_valid, in_byte, in_last, out_ready,
    output in_ready, out_valid, out_word, out_bytes, word_count
  );

  modport master (
    output in_valid, in_byte, in_last, out_ready,
    input  in_ready, out_valid, out_word, out_bytes, word_count
  );
endinterface

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words.
//   MSB_FIRST : 1 = first byte in out_word[31:24], 0 = first byte in out_word[7:0]
//   clk       : single clock, rising edge
//   rst_n     : asynchronous active-low reset
//   bus       : byte_word_packer_if.slave (byte input, word output, word_count)
// Four bytes, or fewer when in_last is set, make one word. A completed word
// sits in the output register until the consumer takes it; while it is
// stalled no further bytes are accepted.
module byte_word_packer #(
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                 clk,
  input logic                 rst_n,
  byte_word_packer_if.slave   bus
);

  logic [1:0]  cnt;
  logic [31:0] acc;
  logic [31:0] acc_with_byte;
  logic [4:0]  shift;
  logic        out_valid_q;
  logic [31:0] out_word_q;
  logic [2:0]  out_bytes_q;
  logic [15:0] word_count_q;

  logic accept;
  logic handoff;
  logic complete;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign bus.in_ready = rst_n && (!out_valid_q || bus.out_ready);

  assign accept   = bus.in_valid && bus.in_ready;
  assign handoff  = out_valid_q && bus.out_ready;
  assign complete = accept && (bus.in_last || (cnt == 2'd3));

  // NOTE: every always_comb output gets a value on every path so no latch is inferred.
  always_comb begin
    shift         = MSB_FIRST ? (5'd24 - {cnt, 3'b000}) : {cnt, 3'b000};
    // Accumulator lanes above cnt are always zero, so OR places the byte.
    acc_with_byte = acc | ({24'd0, bus.in_byte} << shift);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= 2'd0;
      acc          <= 32'd0;
      out_valid_q  <= 1'b0;
      out_word_q   <= 32'd0;
      out_bytes_q  <= 3'd0;
      word_count_q <= 16'd0;
    end else begin
      if (handoff) begin
        word_count_q <= word_count_q + 16'd1;
      end

      if (accept) begin
        if (complete) begin
          cnt <= 2'd0;
          acc <= 32'd0;
        end else begin
          cnt <= cnt + 2'd1;
          acc <= acc_with_byte;
        end
      end

      // Completion wins over hand-off so back-to-back words keep out_valid high.
      if (complete) begin
        out_valid_q <= 1'b1;
        out_word_q  <= acc_with_byte;
        out_bytes_q <= {1'b0, cnt} + 3'd1;
      end else if (handoff) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.out_word   = out_word_q;
  assign bus.out_bytes  = out_bytes_q;
  assign bus.word_count = word_count_q;

endmodule

// File: doc/byte_word_packer.md
BYTE_WORD_PACKER -- requirements
Module: byte_word_packer

Interface
REQ-001 SHALL have parameter MSB_FIRST, default 1; 1 = first byte of a word lands in out_word[31:24] (big-endian), 0 = first byte lands in out_word[7:0] (little-endian).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  in_byte is valid this cycle.
REQ-005 SHALL have port in_ready  output  1  block accepts in_byte this cycle.
REQ-006 SHALL have port in_byte  input  8  incoming byte.
REQ-007 SHALL have port in_last  input  1  accepted byte ends the current word early (flush).
REQ-008 SHALL have port out_valid  output  1  out_word holds a completed word.
REQ-009 SHALL have port out_ready  input  1  consumer takes out_word this cycle.
REQ-010 SHALL have port out_word  output  32  assembled word.
REQ-011 SHALL have port out_bytes  output  3  number of valid byte lanes in out_word, 1..4.
REQ-012 SHALL have port word_count  output  16  number of words handed off, modulo 2^16.

Function
REQ-013 SHALL treat a byte as accepted when in_valid && in_ready at a rising edge, and a word as handed off when out_valid && out_ready at a rising edge.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational); no input is accepted while a completed word is stalled.
REQ-015 SHALL hold a lane counter cnt (0..3) and a 32-bit accumulator; each accepted byte is written to lane cnt.
REQ-016 Lane mapping SHALL be: MSB_FIRST=1 -> lane k occupies bits [31-8k:24-8k]; MSB_FIRST=0 -> lane k occupies bits [8k+7:8k].
REQ-017 An accepted byte with cnt<3 and in_last=0 SHALL increment cnt and leave the output register unchanged.
REQ-018 An accepted byte with cnt==3, or with in_last=1 at any cnt, SHALL complete the word.
REQ-019 On word completion, next cycle: out_word = accumulator including this byte; unfilled lanes = 0; out_bytes = cnt+1; out_valid = 1; cnt = 0; accumulator cleared.
REQ-020 Latency: out_valid SHALL assert exactly one cycle after the completing byte is accepted.
REQ-021 out_word and out_bytes SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 On hand-off without a simultaneous completion, out_valid SHALL clear next cycle.
REQ-023 Hand-off and completion in the same cycle SHALL load the new word with out_valid held at 1; sustained 4-byte streams run with no bubble.
REQ-024 word_count SHALL increment by 1 on each hand-off and wrap 0xFFFF -> 0x0000.
REQ-025 in_last with in_valid=0 or in_ready=0 SHALL be ignored.
REQ-026 The block SHALL accept no byte while rst_n=0; in_ready is 0 during reset.

Reset
REQ-027 rst_n low SHALL immediately clear cnt, accumulator, out_word=0, out_bytes=0, out_valid=0, word_count=0, regardless of clock.
REQ-028 Reset mid-word SHALL discard the partial word; the first byte accepted after release goes to lane 0.
REQ-029 After rst_n rises, in_ready SHALL be 1 from the first clock edge.

Verification
REQ-030 MSB_FIRST=1, out_ready=1, bytes 11,22,33,44 on consecutive cycles -> one cycle after 44: out_word=0x11223344, out_bytes=4, out_valid=1 for one cycle, word_count=1.
REQ-031 MSB_FIRST=0, same stimulus -> out_word=0x44332211, out_bytes=4.
REQ-032 MSB_FIRST=1, AA then BB with in_last=1 -> out_word=0xAABB0000, out_bytes=2; next byte CC lands in lane 0.
REQ-033 out_ready=0 after a completed word; drive 8 more bytes -> in_ready=0, out_word stable; release out_ready -> next 4 bytes accepted, second word delivered, word_count=2.
REQ-034 Two bytes accepted, rst_n pulsed low between edges -> outputs 0 immediately; then 01,02,03,04 -> out_word=0x01020304 (MSB_FIRST=1).
REQ-035 Continuous 4-byte stream for 65537 words with out_ready=1 -> no bubbles, word_count wraps to 0x0001.
